// File: rtl/mem_port_arbiter_if.sv
//==============================================================================
// Module      : mem_port_arbiter_if
// Description : Bundles the fetch, data-access and shared-memory signals of the
//               memory port arbiter; the master view belongs to the arbiter.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Instruction fetch side
    logic                  if_req;
    logic [ADDR_W-1:0]     if_addr;
    logic [DATA_W-1:0]     if_rdata;
    logic                  if_done;
    logic                  if_stall;

    // Data access side
    logic                  dm_read;
    logic                  dm_write;
    logic [ADDR_W-1:0]     dm_addr;
    logic [DATA_W-1:0]     dm_wdata;
    logic [DATA_W/8-1:0]   dm_web;
    logic [DATA_W-1:0]     dm_rdata;
    logic                  dm_done;
    logic                  dm_stall;

    // Shared memory side
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W/8-1:0]   mem_web;
    logic [DATA_W-1:0]     mem_rdata;
    logic                  mem_ready;

    logic                  timeout_err;

    modport master (
        input  if_req, if_addr,
        output if_rdata, if_done, if_stall,
        input  dm_read, dm_write, dm_addr, dm_wdata, dm_web,
        output dm_rdata, dm_done, dm_stall,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_web,
        input  mem_rdata, mem_ready,
        output timeout_err
    );

    modport slave (
        output if_req, if_addr,
        input  if_rdata, if_done, if_stall,
        output dm_read, dm_write, dm_addr, dm_wdata, dm_web,
        input  dm_rdata, dm_done, dm_stall,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_web,
        output mem_rdata, mem_ready,
        input  timeout_err
    );
endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
//==============================================================================
// Module      : mem_port_arbiter
// Description : Serialises fetch and data accesses onto one variable-latency
//               memory port, with per-requester stalls and an abort watchdog.
//               Define FAIR_RR_EN for round-robin tie-breaking (default: DM wins).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module mem_port_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_port_arbiter_if.master bus
);

    localparam int c_WEB_W = DATA_W / 8;
    localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [c_CNT_W-1:0] c_WDOG_MAX = c_CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_DM_ACC = 2'd1;
    localparam logic [1:0] c_IF_ACC = 2'd2;

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_wdog;
    logic               r_mem_req;
    logic               r_mem_we;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [DATA_W-1:0]  r_mem_wdata;
    logic [c_WEB_W-1:0] r_mem_web;
    logic               r_timeout_err;

    logic w_dm_req;
    logic w_grant_dm;
    logic w_grant_if;
    logic w_in_acc;
    logic w_timeout;
    logic w_finish;

    assign w_dm_req = bus.dm_read | bus.dm_write;

`ifdef FAIR_RR_EN
    // Set when the most recent grant went to DM; reset value means IF.
    logic r_last_dm;

    assign w_grant_dm = w_dm_req & (~bus.if_req | ~r_last_dm);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_dm <= 1'b0;
        end else if (r_state == c_IDLE && (w_grant_dm || w_grant_if)) begin
            r_last_dm <= w_grant_dm;
        end
    end
`else
    assign w_grant_dm = w_dm_req;
`endif

    assign w_grant_if = bus.if_req & ~w_grant_dm;

    assign w_in_acc  = (r_state == c_DM_ACC) || (r_state == c_IF_ACC);
    // A ready arriving on the last allowed cycle still completes normally.
    assign w_timeout = w_in_acc & ~bus.mem_ready & (r_wdog == c_WDOG_MAX);
    assign w_finish  = w_in_acc & (bus.mem_ready | w_timeout);

    assign bus.if_done  = (r_state == c_IF_ACC) & w_finish;
    assign bus.dm_done  = (r_state == c_DM_ACC) & w_finish;
    assign bus.if_rdata = ((r_state == c_IF_ACC) && bus.mem_ready) ? bus.mem_rdata : '0;
    assign bus.dm_rdata = ((r_state == c_DM_ACC) && bus.mem_ready) ? bus.mem_rdata : '0;
    assign bus.if_stall = bus.if_req & ~bus.if_done;
    assign bus.dm_stall = w_dm_req & ~bus.dm_done;

    assign bus.mem_req     = r_mem_req;
    assign bus.mem_we      = r_mem_we;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.mem_wdata   = r_mem_wdata;
    assign bus.mem_web     = r_mem_web;
    assign bus.timeout_err = r_timeout_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= c_IDLE;
            r_wdog        <= '0;
            r_mem_req     <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_mem_web     <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_wdog <= '0;
                    if (w_grant_dm) begin
                        r_state     <= c_DM_ACC;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= bus.dm_write;
                        r_mem_addr  <= bus.dm_addr;
                        r_mem_wdata <= bus.dm_wdata;
                        r_mem_web   <= bus.dm_write ? bus.dm_web : '0;
                    end else if (w_grant_if) begin
                        r_state    <= c_IF_ACC;
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= bus.if_addr;
                        r_mem_web  <= '0;
                    end
                end
                c_DM_ACC, c_IF_ACC: begin
                    if (w_finish) begin
                        r_state   <= c_IDLE;
                        r_wdog    <= '0;
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_mem_web <= '0;
                        if (w_timeout) begin
                            r_timeout_err <= 1'b1;
                        end
                    end else begin
                        r_wdog <= r_wdog + c_CNT_W'(1);
                    end
                end
                default: begin
                    r_state   <= c_IDLE;
                    r_mem_req <= 1'b0;
                    r_mem_we  <= 1'b0;
                    r_mem_web <= '0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
//==============================================================================
// Module      : tb_mem_port_arbiter
// Description : Scoreboard bench for mem_port_arbiter with a behavioural memory.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mem_port_arbiter;

    localparam int c_AW = 32;
    localparam int c_DW = 32;
    localparam int c_TO = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(c_AW), .DATA_W(c_DW)) bus();

    mem_port_arbiter #(
        .ADDR_W        (c_AW),
        .DATA_W        (c_DW),
        .TIMEOUT_CYCLES(c_TO)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.master)
    );

    typedef struct packed {
        logic        is_dm;
        logic        we;
        logic [3:0]  web;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb[$];
    int          checks  = 0;
    int          errors  = 0;
    int          lat     = 1;
    bit          hang    = 1'b0;
    int          acc_cnt = 0;
    logic [31:0] img [logic [31:0]];

    function automatic logic [31:0] lookup(input logic [31:0] a);
        if (img.exists(a)) return img[a];
        return 32'h0;
    endfunction

    function automatic exp_t mk(input bit dm, input bit we, input logic [3:0] web,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] rd);
        exp_t e;
        e.is_dm = dm; e.we = we; e.web = web; e.addr = a; e.wdata = wd; e.rdata = rd;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Returns the index of the cycle (0 = current) in which the selected done appears.
    task automatic wait_done(input bit dm, output int k);
        k = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #3;
            if (dm ? bus.dm_done : bus.if_done) begin
                k = i;
                break;
            end
        end
        if (k < 0) begin
            checks++;
            errors++;
            $display("FAIL wait_done(%0d): no done within 40 cycles", dm);
        end
    endtask

    // Behavioural memory: ready after 'lat' access cycles unless hung.
    initial begin
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'hFFFF_FFFF;
        forever begin
            @(negedge clk);
            if (!rst_n || !bus.mem_req) begin
                acc_cnt       = 0;
                bus.mem_ready = 1'b0;
                bus.mem_rdata = 32'hFFFF_FFFF;
            end else begin
                acc_cnt++;
                bus.mem_rdata = lookup(bus.mem_addr);
                bus.mem_ready = (!hang && acc_cnt == lat);
            end
        end
    end

    // Monitor: memory-side fields against the head entry, responses on done.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n) begin
                if (!bus.if_done) chk("if_rdata_idle", bus.if_rdata, 32'h0);
                if (!bus.dm_done) chk("dm_rdata_idle", bus.dm_rdata, 32'h0);
                if (bus.mem_req) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL spurious_req: mem_req=1 addr %h with nothing expected", bus.mem_addr);
                    end else begin
                        e = sb[0];
                        chk("mem_addr", bus.mem_addr, e.addr);
                        chk("mem_we", {31'b0, bus.mem_we}, {31'b0, e.we});
                        chk("mem_web", {28'b0, bus.mem_web}, {28'b0, e.web});
                        if (e.we) chk("mem_wdata", bus.mem_wdata, e.wdata);
                    end
                end
                if (bus.if_done || bus.dm_done) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: if_done=%0d dm_done=%0d", bus.if_done, bus.dm_done);
                    end else begin
                        e = sb.pop_front();
                        chk("done_dm", {31'b0, bus.dm_done}, {31'b0, e.is_dm});
                        chk("done_if", {31'b0, bus.if_done}, {31'b0, ~e.is_dm});
                        chk("rdata", e.is_dm ? bus.dm_rdata : bus.if_rdata, e.rdata);
                    end
                end
            end
        end
    end

    initial begin
        int k;
        bus.if_req   = 1'b0; bus.if_addr  = '0;
        bus.dm_read  = 1'b0; bus.dm_write = 1'b0;
        bus.dm_addr  = '0;   bus.dm_wdata = '0;  bus.dm_web = '0;
        img[32'h100]  = 32'hDEAD_BEEF;
        img[32'h104]  = 32'h1111_2222;
        img[32'h108]  = 32'h3333_4444;
        img[32'h3000] = 32'hA0A0_0001;
        img[32'h3008] = 32'hA0A0_0002;
        img[32'h4000] = 32'h7777_7777;
        img[32'h5000] = 32'h55AA_55AA;
        img[32'h6000] = 32'h6600_6600;

        #2;
        chk("rst_mem_req", {31'b0, bus.mem_req}, 32'h0);
        chk("rst_mem_we", {31'b0, bus.mem_we}, 32'h0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_timeout_err", {31'b0, bus.timeout_err}, 32'h0);
        cyc(); cyc();
        rst_n = 1'b1;
        cyc();

        // Fetch only, single-cycle memory
        lat = 1;
        sb.push_back(mk(1'b0, 1'b0, 4'h0, 32'h100, 32'h0, 32'hDEAD_BEEF));
        bus.if_req = 1'b1; bus.if_addr = 32'h100;
        #1;
        chk("fetch_stall_req", {31'b0, bus.if_stall}, 32'h1);
        chk("fetch_no_req_yet", {31'b0, bus.mem_req}, 32'h0);
        wait_done(1'b0, k);
        chk("fetch_latency", k, 32'd1);
        chk("fetch_stall_done", {31'b0, bus.if_stall}, 32'h0);
        cyc();
        bus.if_req = 1'b0;

        // Simultaneous IF + DM
`ifdef FAIR_RR_EN
        sb.push_back(mk(1'b1, 1'b0, 4'h0, 32'h3000, 32'h0, 32'hA0A0_0001));
        sb.push_back(mk(1'b0, 1'b0, 4'h0, 32'h104,  32'h0, 32'h1111_2222));
        sb.push_back(mk(1'b1, 1'b0, 4'h0, 32'h3008, 32'h0, 32'hA0A0_0002));
        sb.push_back(mk(1'b0, 1'b0, 4'h0, 32'h108,  32'h0, 32'h3333_4444));
        bus.dm_read = 1'b1; bus.dm_addr = 32'h3000;
        bus.if_req  = 1'b1; bus.if_addr = 32'h104;
        wait_done(1'b1, k);
        chk("rr_dm1_latency", k, 32'd1);
        chk("rr_if_stalled", {31'b0, bus.if_stall}, 32'h1);
        cyc();
        bus.dm_addr = 32'h3008;
        wait_done(1'b0, k);
        chk("rr_if1_latency", k, 32'd1);
        cyc();
        bus.if_addr = 32'h108;
        wait_done(1'b1, k);
        chk("rr_dm2_latency", k, 32'd1);
        cyc();
        bus.dm_read = 1'b0;
        wait_done(1'b0, k);
        chk("rr_if2_latency", k, 32'd1);
        cyc();
        bus.if_req = 1'b0;
`else
        sb.push_back(mk(1'b1, 1'b0, 4'h0, 32'h3000, 32'h0, 32'hA0A0_0001));
        sb.push_back(mk(1'b1, 1'b0, 4'h0, 32'h3008, 32'h0, 32'hA0A0_0002));
        sb.push_back(mk(1'b0, 1'b0, 4'h0, 32'h104,  32'h0, 32'h1111_2222));
        bus.dm_read = 1'b1; bus.dm_addr = 32'h3000;
        bus.if_req  = 1'b1; bus.if_addr = 32'h104;
        wait_done(1'b1, k);
        chk("prio_dm1_latency", k, 32'd1);
        chk("prio_if_stalled", {31'b0, bus.if_stall}, 32'h1);
        cyc();
        bus.dm_addr = 32'h3008;
        wait_done(1'b1, k);
        chk("prio_dm2_latency", k, 32'd1);
        cyc();
        bus.dm_read = 1'b0;
        wait_done(1'b0, k);
        chk("prio_if_after_dm", k, 32'd1);
        cyc();
        bus.if_req = 1'b0;
`endif

        // Store with a three-cycle memory
        lat = 3;
        sb.push_back(mk(1'b1, 1'b1, 4'b0011, 32'h2004, 32'h1234_5678, 32'h0));
        bus.dm_write = 1'b1; bus.dm_addr = 32'h2004;
        bus.dm_wdata = 32'h1234_5678; bus.dm_web = 4'b0011;
        #1;
        chk("store_stall_req", {31'b0, bus.dm_stall}, 32'h1);
        wait_done(1'b1, k);
        chk("store_latency", k, 32'd3);
        cyc();
        bus.dm_write = 1'b0; bus.dm_wdata = '0; bus.dm_web = '0;

        // Ready on the last allowed cycle wins over the watchdog
        lat = c_TO;
        sb.push_back(mk(1'b1, 1'b0, 4'h0, 32'h5000, 32'h0, 32'h55AA_55AA));
        bus.dm_read = 1'b1; bus.dm_addr = 32'h5000;
        wait_done(1'b1, k);
        chk("edge_latency", k, c_TO);
        cyc();
        bus.dm_read = 1'b0;
        chk("edge_no_timeout", {31'b0, bus.timeout_err}, 32'h0);

        // Hung memory: watchdog abort
        hang = 1'b1;
        sb.push_back(mk(1'b1, 1'b0, 4'h0, 32'h4000, 32'h0, 32'h0));
        bus.dm_read = 1'b1; bus.dm_addr = 32'h4000;
        wait_done(1'b1, k);
        chk("timeout_latency", k, c_TO);
        chk("timeout_err_not_yet", {31'b0, bus.timeout_err}, 32'h0);
        cyc();
        bus.dm_read = 1'b0;
        hang = 1'b0;
        chk("timeout_err_set", {31'b0, bus.timeout_err}, 32'h1);

        // Later access still works and the error stays sticky
        lat = 2;
        sb.push_back(mk(1'b0, 1'b0, 4'h0, 32'h108, 32'h0, 32'h3333_4444));
        bus.if_req = 1'b1; bus.if_addr = 32'h108;
        wait_done(1'b0, k);
        chk("post_timeout_latency", k, 32'd2);
        cyc();
        bus.if_req = 1'b0;
        chk("timeout_err_sticky", {31'b0, bus.timeout_err}, 32'h1);

        // Reset mid-access, held request re-issued afterwards
        hang = 1'b1;
        sb.push_back(mk(1'b1, 1'b0, 4'h0, 32'h6000, 32'h0, 32'h6600_6600));
        bus.dm_read = 1'b1; bus.dm_addr = 32'h6000;
        cyc(); cyc(); cyc();
        chk("pre_reset_mem_req", {31'b0, bus.mem_req}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_mem_req", {31'b0, bus.mem_req}, 32'h0);
        chk("async_reset_no_done", {31'b0, bus.dm_done}, 32'h0);
        chk("reset_clears_err", {31'b0, bus.timeout_err}, 32'h0);
        hang = 1'b0;
        lat  = 2;
        cyc();
        rst_n = 1'b1;
        wait_done(1'b1, k);
        chk("reissue_latency", k, 32'd2);
        cyc();
        bus.dm_read = 1'b0;

        cyc(); cyc(); cyc();
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
